// File: rtl/press_arbiter.sv
// Serialises two players' press pulses into one registered move pulse at a time, with a COOLDOWN gap, round-robin ties.
// Latency 1 clk press->move; one pending press buffered per player, further presses dropped and counted (saturating).
module press_arbiter #(
    parameter int COOLDOWN = 4,
    parameter int DROP_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              p1_press,
    input  logic              p2_press,
    output logic              p1_move,
    output logic              p2_move,
    output logic              busy,
    output logic              p1_pend,
    output logic              p2_pend,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam logic [7:0]      COOL_LEN = 8'(COOLDOWN);
    localparam logic [DROP_W:0] DROP_MAX = {1'b0, {DROP_W{1'b1}}};

    typedef enum logic {
        IDLE = 1'b0,
        COOL = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [7:0]      cnt, cnt_nxt;
    logic            prio, prio_nxt;   // 0: player 1 wins the next tie, 1: player 2
    logic            pend1_nxt, pend2_nxt;
    logic            move1_nxt, move2_nxt;
    logic            drop1, drop2;
    logic            req1, req2, win2;
    logic [DROP_W:0] drop_sum;

    assign req1 = p1_press | p1_pend;
    assign req2 = p2_press | p2_pend;
    assign win2 = req2 & (~req1 | prio);
    assign busy = (state == COOL);

    // One extra bit of headroom so that a double drop near the top still saturates cleanly.
    assign drop_sum = {1'b0, drop_cnt} + {{DROP_W{1'b0}}, drop1} + {{DROP_W{1'b0}}, drop2};

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        prio_nxt  = prio;
        pend1_nxt = p1_pend;
        pend2_nxt = p2_pend;
        move1_nxt = 1'b0;
        move2_nxt = 1'b0;
        drop1     = 1'b0;
        drop2     = 1'b0;

        if (!enable) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            pend1_nxt = 1'b0;
            pend2_nxt = 1'b0;
        end else if (state == IDLE) begin
            if (req1 || req2) begin
                state_nxt = COOL;
                cnt_nxt   = COOL_LEN;
                if (win2) begin
                    move2_nxt = 1'b1;
                    pend2_nxt = 1'b0;
                    prio_nxt  = 1'b0;
                    if (p1_press) begin
                        if (p1_pend) drop1 = 1'b1;
                        else         pend1_nxt = 1'b1;
                    end
                end else begin
                    move1_nxt = 1'b1;
                    pend1_nxt = 1'b0;
                    prio_nxt  = 1'b1;
                    if (p2_press) begin
                        if (p2_pend) drop2 = 1'b1;
                        else         pend2_nxt = 1'b1;
                    end
                end
            end
        end else begin
            // Presses landing on the final cooldown edge are buffered, granted one edge later.
            cnt_nxt = cnt - 8'd1;
            if (cnt <= 8'd1) state_nxt = IDLE;
            if (p1_press) begin
                if (p1_pend) drop1 = 1'b1;
                else         pend1_nxt = 1'b1;
            end
            if (p2_press) begin
                if (p2_pend) drop2 = 1'b1;
                else         pend2_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            prio     <= 1'b0;
            p1_pend  <= 1'b0;
            p2_pend  <= 1'b0;
            p1_move  <= 1'b0;
            p2_move  <= 1'b0;
            drop_cnt <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            prio     <= prio_nxt;
            p1_pend  <= pend1_nxt;
            p2_pend  <= pend2_nxt;
            p1_move  <= move1_nxt;
            p2_move  <= move2_nxt;
            drop_cnt <= (drop_sum > DROP_MAX) ? DROP_MAX[DROP_W-1:0] : drop_sum[DROP_W-1:0];
        end
    end

endmodule

// File: tb/tb_press_arbiter.sv
// Bench for press_arbiter: directed vector table, hand-written corner sequences, random stimulus vs a cycle-budget model.
module tb_press_arbiter;

    localparam int COOLDOWN = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       p1_press = 1'b0;
    logic       p2_press = 1'b0;
    logic       p1_move, p2_move, busy, p1_pend, p2_pend;
    logic [7:0] drop_cnt;
    logic       s_p1_move, s_p2_move, s_busy, s_p1_pend, s_p2_pend;
    logic [1:0] s_drop_cnt;

    press_arbiter #(.COOLDOWN(COOLDOWN), .DROP_W(8)) dut (
        .clk(clk), .reset(reset), .enable(enable), .p1_press(p1_press), .p2_press(p2_press),
        .p1_move(p1_move), .p2_move(p2_move), .busy(busy), .p1_pend(p1_pend), .p2_pend(p2_pend),
        .drop_cnt(drop_cnt)
    );

    press_arbiter #(.COOLDOWN(COOLDOWN), .DROP_W(2)) dut_s (
        .clk(clk), .reset(reset), .enable(enable), .p1_press(p1_press), .p2_press(p2_press),
        .p1_move(s_p1_move), .p2_move(s_p2_move), .busy(s_busy), .p1_pend(s_p1_pend), .p2_pend(s_p2_pend),
        .drop_cnt(s_drop_cnt)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Reference model: a grant is allowed at edge index >= m_free; the cycle after edge e is busy while e+1 < m_free.
    int m_edge = 0;
    int m_free = 0;
    int m_drops = 0;
    bit m_pend1, m_pend2, m_prio, m_mv1, m_mv2;

    typedef struct {
        bit en, a, b;
        bit m1, m2, bz, q1, q2;
        int d;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic model_reset();
        m_free = 0; m_drops = 0;
        m_pend1 = 0; m_pend2 = 0; m_prio = 0; m_mv1 = 0; m_mv2 = 0;
    endtask

    task automatic model_buffer(input bit press, inout bit pend);
        if (press) begin
            if (pend) m_drops++;
            else      pend = 1;
        end
    endtask

    task automatic model_edge(input bit en, input bit a, input bit b);
        bit r1, r2;
        int winner;
        m_mv1 = 0; m_mv2 = 0;
        r1 = a | m_pend1;
        r2 = b | m_pend2;
        if (!en) begin
            m_pend1 = 0; m_pend2 = 0;
            m_free  = m_edge + 1;
        end else if (m_edge >= m_free && (r1 || r2)) begin
            winner = (r1 && r2) ? (m_prio ? 2 : 1) : (r1 ? 1 : 2);
            if (winner == 1) begin
                m_mv1 = 1; m_pend1 = 0; m_prio = 1;
                model_buffer(b, m_pend2);
            end else begin
                m_mv2 = 1; m_pend2 = 0; m_prio = 0;
                model_buffer(a, m_pend1);
            end
            m_free = m_edge + COOLDOWN + 1;
        end else begin
            model_buffer(a, m_pend1);
            model_buffer(b, m_pend2);
        end
        m_edge++;
    endtask

    task automatic tick(input bit en, input bit a, input bit b);
        enable = en; p1_press = a; p2_press = b;
        @(posedge clk);
        model_edge(en, a, b);
        #1;
    endtask

    task automatic cmp_model(input string tag);
        bit exp_busy;
        exp_busy = (m_edge < m_free);
        chk({tag, ".p1_move"}, p1_move, m_mv1);
        chk({tag, ".p2_move"}, p2_move, m_mv2);
        chk({tag, ".busy"}, busy, exp_busy);
        chk({tag, ".p1_pend"}, p1_pend, m_pend1);
        chk({tag, ".p2_pend"}, p2_pend, m_pend2);
        chk({tag, ".drop_cnt"}, drop_cnt, (m_drops > 255) ? 255 : m_drops);
        chk({tag, ".s_drop_cnt"}, s_drop_cnt, (m_drops > 3) ? 3 : m_drops);
        chk({tag, ".s_moves"}, {s_p1_move, s_p2_move}, {m_mv1, m_mv2});
        chk({tag, ".s_state"}, {s_busy, s_p1_pend, s_p2_pend}, {exp_busy, m_pend1, m_pend2});
    endtask

    task automatic step(input bit en, input bit a, input bit b, input string tag);
        tick(en, a, b);
        cmp_model(tag);
    endtask

    task automatic do_reset();
        p1_press = 0; p2_press = 0;
        reset = 1;
        model_reset();
        @(posedge clk);
        #1 reset = 0;
    endtask

    task automatic add(input bit en, input bit a, input bit b, input bit m1, input bit m2, input bit bz,
                       input bit q1, input bit q2, input int d, input int n = 1);
        vec_t v;
        v.en = en; v.a = a; v.b = b; v.m1 = m1; v.m2 = m2; v.bz = bz; v.q1 = q1; v.q2 = q2; v.d = d;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    int sat2[9] = '{0, 0, 1, 2, 3, 3, 3, 3, 3};
    int sat8[9] = '{0, 0, 1, 2, 3, 3, 4, 5, 6};
    bit seq_a[9] = '{1, 0, 0, 0, 0, 1, 1, 1, 1};
    bit seq_b[9] = '{0, 1, 1, 1, 1, 0, 0, 0, 0};

    initial begin
        // Row k is applied before edge k; its expectation is the cycle that follows.
        //  en a  b   m1 m2 bz q1 q2 drop
        add(1, 1, 1,  1, 0, 1, 0, 1, 0);
        add(1, 0, 0,  0, 0, 1, 0, 1, 0, 3);
        add(1, 0, 0,  0, 0, 0, 0, 1, 0);
        add(1, 0, 0,  0, 1, 1, 0, 0, 0);
        add(1, 0, 0,  0, 0, 1, 0, 0, 0, 3);
        add(1, 0, 0,  0, 0, 0, 0, 0, 0);
        add(1, 1, 1,  1, 0, 1, 0, 1, 0);
        add(1, 0, 0,  0, 0, 1, 0, 1, 0, 3);
        add(1, 0, 0,  0, 0, 0, 0, 1, 0);
        add(1, 0, 0,  0, 1, 1, 0, 0, 0);
        add(1, 0, 0,  0, 0, 1, 0, 0, 0, 3);
        add(1, 0, 0,  0, 0, 0, 0, 0, 0);
        add(1, 1, 0,  1, 0, 1, 0, 0, 0);
        add(1, 0, 1,  0, 0, 1, 0, 1, 0);
        add(1, 0, 1,  0, 0, 1, 0, 1, 1);
        add(1, 0, 1,  0, 0, 1, 0, 1, 2);
        add(1, 0, 0,  0, 0, 0, 0, 1, 2);
        add(1, 0, 0,  0, 1, 1, 0, 0, 2);
        add(1, 0, 0,  0, 0, 1, 0, 0, 2, 3);
        add(1, 0, 0,  0, 0, 0, 0, 0, 2);

        model_reset();
        #1 reset = 1;
        #1;
        chk("reset.outputs", {p1_move, p2_move, busy, p1_pend, p2_pend}, 5'b0);
        chk("reset.drop_cnt", drop_cnt, 0);
        @(posedge clk);
        #1 reset = 0;

        foreach (vecs[i]) begin
            tick(vecs[i].en, vecs[i].a, vecs[i].b);
            chk($sformatf("vec%0d.moves", i), {p1_move, p2_move}, {vecs[i].m1, vecs[i].m2});
            chk($sformatf("vec%0d.busy", i), busy, vecs[i].bz);
            chk($sformatf("vec%0d.pends", i), {p1_pend, p2_pend}, {vecs[i].q1, vecs[i].q2});
            chk($sformatf("vec%0d.drop_cnt", i), drop_cnt, vecs[i].d);
        end

        // Asynchronous reset in the middle of a cooldown with player 2 pending.
        step(1, 1, 1, "arst.tie");
        chk("arst.p2_pend_before", p2_pend, 1);
        step(1, 0, 0, "arst.cool");
        #2 reset = 1;
        #1;
        chk("arst.outputs", {p1_move, p2_move, busy, p1_pend, p2_pend}, 5'b0);
        chk("arst.drop_cnt", drop_cnt, 0);
        model_reset();
        @(posedge clk);
        #1 reset = 0;
        step(1, 1, 1, "arst.first_tie");
        chk("arst.first_tie_p1", {p1_move, p2_move}, 2'b10);
        for (int i = 0; i < COOLDOWN + 2; i++) step(1, 0, 0, "arst.drain");

        // Enable low flushes pends but keeps priority and drop count.
        do_reset();
        step(1, 1, 0, "en.grant");
        step(1, 1, 0, "en.pend");
        step(1, 1, 0, "en.drop");
        chk("en.before", {p1_pend, busy, drop_cnt}, {1'b1, 1'b1, 8'd1});
        step(0, 1, 1, "en.low0");
        step(0, 1, 1, "en.low1");
        chk("en.flushed", {p1_move, p2_move, busy, p1_pend, p2_pend}, 5'b0);
        chk("en.drop_held", drop_cnt, 1);
        step(1, 1, 1, "en.resume");
        chk("en.resume_p2_wins", {p1_move, p2_move}, 2'b01);
        for (int i = 0; i < COOLDOWN + 2; i++) step(1, 0, 0, "en.drain");

        // Drop counter saturation on the narrow instance.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(1, seq_a[i], seq_b[i], "sat");
            chk($sformatf("sat%0d.s_drop_cnt", i), s_drop_cnt, sat2[i]);
            chk($sformatf("sat%0d.drop_cnt", i), drop_cnt, sat8[i]);
        end
        for (int i = 0; i < COOLDOWN + 2; i++) step(1, 0, 0, "sat.drain");

        // Press on the edge that leaves cooldown is buffered, then granted one edge later.
        do_reset();
        step(1, 1, 0, "edge.grant");
        for (int i = 0; i < COOLDOWN - 1; i++) step(1, 0, 0, "edge.cool");
        step(1, 0, 1, "edge.exit");
        chk("edge.exit_state", {p2_move, busy, p2_pend}, 3'b001);
        step(1, 0, 0, "edge.grant2");
        chk("edge.grant2_move", {p1_move, p2_move}, 2'b01);

        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(15) != 0, $urandom_range(2) == 0, $urandom_range(2) == 0, "rand");
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
